// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-game timer.
`timescale 1ns/1ps
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_t;

  localparam int unsigned LFSR_W     = 16;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int unsigned MAX_MS_DEF = 9999;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits as the random value.
`timescale 1ns/1ps
module lfsr16
  import reaction_pkg::*;
#(
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] o_rand
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_rand = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/reaction_timer.sv
// Reaction-game sequencer: random wait, GO indication, millisecond reaction measurement
// and foul detection, driven by ticks recovered from the 1 kHz clk_ms square wave.
`timescale 1ns/1ps
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int unsigned MAX_MS    = MAX_MS_DEF,
  parameter int unsigned DELAY_MIN = 1000,
  parameter int unsigned DELAY_W   = 11,
  parameter int unsigned TIME_W    = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_ms,
  input  logic              start,
  input  logic              btn,
  output logic              led_go,
  output logic              busy,
  output logic              done,
  output logic              foul,
  output logic [TIME_W-1:0] react_ms
);

  localparam int unsigned DLY_W = $clog2(DELAY_MIN + (1 << DELAY_W));

  state_t              r_state, w_state_nxt;
  logic [DLY_W-1:0]    r_delay, w_delay_nxt, w_delay_load;
  logic [TIME_W-1:0]   r_ms, w_ms_nxt;
  logic [TIME_W-1:0]   r_react, w_react_nxt;
  logic                r_clk_ms_d, r_btn_d;
  logic                r_led_go, r_busy, r_done, r_foul;
  logic                w_tick, w_btn_rise;
  logic [DELAY_W-1:0]  w_rand;

  lfsr16 #(.OUT_W(DELAY_W)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_rand (w_rand)
  );

  assign w_tick       = clk_ms & ~r_clk_ms_d;
  assign w_btn_rise   = btn & ~r_btn_d;
  assign w_delay_load = DLY_W'(DELAY_MIN) + DLY_W'(w_rand);

  // Next-state and datapath updates; a button rise always beats a coincident tick.
  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_ms_nxt    = r_ms;
    w_react_nxt = r_react;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (start) begin
          w_delay_nxt = w_delay_load;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_btn_rise) begin
          w_state_nxt = ST_FOUL;
        end else if (w_tick) begin
          if (r_delay == DLY_W'(1)) begin
            w_state_nxt = ST_GO;
            w_delay_nxt = '0;
            w_ms_nxt    = '0;
          end else begin
            w_delay_nxt = r_delay - DLY_W'(1);
          end
        end
      end
      ST_GO: begin
        if (w_btn_rise) begin
          w_react_nxt = r_ms;
          w_state_nxt = ST_DONE;
        end else if (w_tick) begin
          if (r_ms == TIME_W'(MAX_MS - 1)) begin
            w_ms_nxt    = TIME_W'(MAX_MS);
            w_react_nxt = TIME_W'(MAX_MS);
            w_state_nxt = ST_DONE;
          end else begin
            w_ms_nxt = r_ms + TIME_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_delay    <= '0;
      r_ms       <= '0;
      r_react    <= '0;
      r_clk_ms_d <= 1'b0;
      r_btn_d    <= 1'b0;
      r_led_go   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_foul     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_delay    <= w_delay_nxt;
      r_ms       <= w_ms_nxt;
      r_react    <= w_react_nxt;
      r_clk_ms_d <= clk_ms;
      r_btn_d    <= btn;
      r_led_go   <= (w_state_nxt == ST_GO);
      r_busy     <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_GO);
      r_done     <= (w_state_nxt == ST_DONE);
      r_foul     <= (w_state_nxt == ST_FOUL);
    end
  end

  assign led_go   = r_led_go;
  assign busy     = r_busy;
  assign done     = r_done;
  assign foul     = r_foul;
  assign react_ms = r_react;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer with a divide-by-40 clk_ms source and a game-level reference model.
`timescale 1ns/1ps
module tb_reaction_timer;

  localparam int MAX_MS    = 20;
  localparam int DELAY_MIN = 3;
  localparam int DELAY_W   = 2;
  localparam int TIME_W    = 14;
  localparam int COUNT_Q   = 20;

  logic clk = 1'b0, rst = 1'b1, clk_ms = 1'b0, start = 1'b0, btn = 1'b0;
  logic led_go, busy, done, foul;
  logic [TIME_W-1:0] react_ms;

  int errors = 0, checks = 0, exp_react = 0, div_cnt = 0;
  logic ms_prev = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  wire  tb_tick = clk_ms & ~ms_prev;

  reaction_timer #(.MAX_MS(MAX_MS), .DELAY_MIN(DELAY_MIN), .DELAY_W(DELAY_W), .TIME_W(TIME_W)) dut (
    .clk(clk), .rst(rst), .clk_ms(clk_ms), .start(start), .btn(btn),
    .led_go(led_go), .busy(busy), .done(done), .foul(foul), .react_ms(react_ms)
  );

  always #5 clk = ~clk;

  // Clock divider model: clk_ms toggles every COUNT_Q system clocks.
  always @(posedge clk) begin
    if (div_cnt == COUNT_Q - 1) begin
      div_cnt <= 0;
      clk_ms  <= ~clk_ms;
    end else begin
      div_cnt <= div_cnt + 1;
    end
    ms_prev <= clk_ms;
  end

  // Reference random sequence: taps 16,14,13,11, seeded on reset.
  always @(posedge clk)
    m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic step(output bit t);
    t = tb_tick;
    @(posedge clk); #1;
  endtask

  task automatic do_start(output int d);
    d = DELAY_MIN + int'(m_lfsr[1:0]);
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || foul !== 1'b0 || led_go !== 1'b0) begin
      errors++;
      $display("FAIL start: busy=%b done=%b foul=%b led_go=%b expected 1 0 0 0", busy, done, foul, led_go);
    end
  endtask

  task automatic wait_go(input int d, input int restart_at);
    int ticks = 0;
    bit t, ok = 0, restarted = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!restarted && restart_at >= 0 && ticks == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      step(t);
      start = 1'b0;
      if (t) ticks++;
      if (led_go === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok || ticks != d || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_len: ok=%0d ticks=%0d busy=%b expected ticks=%0d busy=1", ok, ticks, busy, d);
    end
    checks++;
    if (ticks < DELAY_MIN || ticks > DELAY_MIN + 3) begin
      errors++;
      $display("FAIL wait_range: ticks=%0d expected within [%0d,%0d]", ticks, DELAY_MIN, DELAY_MIN + 3);
    end
  endtask

  task automatic go_phase(input int n, input bit coincide, input bit timeout);
    int cnt = 0;
    bit t, fin = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!timeout && cnt == n && (!coincide || tb_tick)) begin
        btn = 1'b1;
        step(t);
        btn = 1'b0;
        fin = 1;
        break;
      end
      step(t);
      if (t) cnt++;
      if (done === 1'b1) begin fin = 1; break; end
    end
    exp_react = timeout ? MAX_MS : n;
    checks++;
    if (!fin || done !== 1'b1 || int'(react_ms) != exp_react) begin
      errors++;
      $display("FAIL react: fin=%0d done=%b react_ms=%0d expected done=1 react_ms=%0d", fin, done, react_ms, exp_react);
    end
    checks++;
    if (led_go !== 1'b0 || busy !== 1'b0 || foul !== 1'b0) begin
      errors++;
      $display("FAIL go_exit: led_go=%b busy=%b foul=%b expected 0 0 0", led_go, busy, foul);
    end
    if (timeout) begin
      checks++;
      if (cnt != MAX_MS) begin
        errors++;
        $display("FAIL timeout_ticks: ticks=%0d expected %0d", cnt, MAX_MS);
      end
    end
  endtask

  task automatic check_foul(input string name);
    checks++;
    if (foul !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || led_go !== 1'b0 || int'(react_ms) != exp_react) begin
      errors++;
      $display("FAIL %s: foul=%b done=%b busy=%b led_go=%b react_ms=%0d expected 1 0 0 0 %0d",
               name, foul, done, busy, led_go, react_ms, exp_react);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if (led_go !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || foul !== 1'b0 || react_ms !== '0 ||
        3'(dut.r_state) !== 3'd0 || dut.u_lfsr.r_lfsr !== 16'hACE1) begin
      errors++;
      $display("FAIL reset: led_go=%b busy=%b done=%b foul=%b react=%0d state=%0d lfsr=%h expected zeros, lfsr=ace1",
               led_go, busy, done, foul, react_ms, 3'(dut.r_state), dut.u_lfsr.r_lfsr);
    end
    rst = 1'b0;
    exp_react = 0;
    repeat (2) cyc();
  endtask

  task automatic test_foul();
    int d;
    do_start(d);
    repeat ($urandom_range(1, 30)) cyc();
    btn = 1'b1; cyc(); btn = 1'b0;
    check_foul("foul_early");
    repeat (3) cyc();
    btn = 1'b1; cyc(); btn = 1'b0; cyc();
    check_foul("foul_hold");
  endtask

  task automatic test_normal();
    int d;
    do_start(d);
    wait_go(d, -1);
    go_phase(5, 1'b0, 1'b0);
    repeat (4) cyc();
    btn = 1'b1; cyc(); btn = 1'b0; cyc();
    checks++;
    if (done !== 1'b1 || int'(react_ms) != 5) begin
      errors++;
      $display("FAIL done_hold: done=%b react_ms=%0d expected 1 5", done, react_ms);
    end
  endtask

  task automatic test_coincide();
    int d, ticks = 0;
    bit t;
    do_start(d);
    wait_go(d, -1);
    go_phase(7, 1'b1, 1'b0);
    do_start(d);
    for (int i = 0; i < 2000; i++) begin
      if (ticks == d - 1 && tb_tick) break;
      step(t);
      if (t) ticks++;
    end
    btn = 1'b1; cyc(); btn = 1'b0;
    check_foul("foul_final_tick");
  endtask

  task automatic test_timeout();
    int d;
    do_start(d);
    wait_go(d, -1);
    go_phase(0, 1'b0, 1'b1);
  endtask

  task automatic test_busy_guard();
    int d;
    do_start(d);
    wait_go(d, 1);
    go_phase(int'($urandom_range(1, MAX_MS - 1)), 1'b0, 1'b0);
  endtask

  task automatic test_random_runs();
    int d;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 60)) cyc();
      do_start(d);
      wait_go(d, -1);
      go_phase(int'($urandom_range(1, MAX_MS - 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_go();
    int d;
    do_start(d);
    wait_go(d, -1);
    repeat (50) cyc();
    test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || react_ms !== '0 || 3'(dut.r_state) !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b react=%0d state=%0d expected idle zeros",
               busy, done, react_ms, 3'(dut.r_state));
    end
  endtask

  initial begin
    test_reset();
    test_foul();
    test_normal();
    test_coincide();
    test_timeout();
    test_busy_guard();
    test_random_runs();
    test_reset_mid_go();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
